// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Posted-write store buffer between a CPU and data memory. CPU stores are
// queued in a circular FIFO and drained to memory in issue order, one entry
// per memReq/memAck handshake. A store arriving while the buffer is full is
// dropped and recorded in the sticky sbOverflow flag.
//
// Optional feature, macro STORE_BUFFER_FORWARD_EN:
//   defined   -> store-to-load forwarding; lookupAddress is compared against
//                every valid entry and the youngest match is returned.
//   undefined -> lookupHit/lookupData are tied to zero and no address
//                comparators exist.
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH  = 4,   // power of two, >= 2
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    // CPU store port
    input  logic                     sbWriteEnabled,
    input  logic [ADDR_W-1:0]        sbAddress,
    input  logic [DATA_W-1:0]        sbWriteInput,
    output logic                     sbFull,
    output logic                     sbEmpty,
    output logic [$clog2(DEPTH):0]   sbCount,
    output logic                     sbOverflow,
    // Memory drain port
    output logic                     memReq,
    output logic [ADDR_W-1:0]        memAddress,
    output logic [DATA_W-1:0]        memWriteData,
    input  logic                     memAck,
    // Load forwarding port
    input  logic [ADDR_W-1:0]        lookupAddress,
    output logic                     lookupHit,
    output logic [DATA_W-1:0]        lookupData
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Registered state
    entry_t             entries_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    // Per-cycle handshake decisions
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    entry_t             entry_d;

    // Status is decoded from the registered count only, so it never depends
    // on this cycle's inputs.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A store is accepted only when not full; a same-cycle ack does not make
    // room for it. An ack is honoured only while a request is outstanding.
    assign push    = sbWriteEnabled & ~full;
    assign pop     = memAck & ~empty;
    assign entry_d = '{addr: sbAddress, data: sbWriteInput};

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no
        // path leaves it unassigned, which would otherwise infer a latch.
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        // Pointers are exactly PTR_W bits wide, so +1 wraps modulo DEPTH.
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;   // idle, or push and pop together
        endcase

        if (sbWriteEnabled && full) begin
            overflow_d = 1'b1;
        end
    end

    // Control state registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage: written at the tail on an accepted store.
    always_ff @(posedge clock) begin
        // NOTE: the storage array is deliberately not reset; an entry is only
        // ever read while the count marks it valid, and leaving it unreset
        // lets it map onto plain RAM/register-file cells.
        if (push) begin
            entries_q[tail_q] <= entry_d;
        end
    end

    assign sbFull       = full;
    assign sbEmpty      = empty;
    assign sbCount      = count_q;
    assign sbOverflow   = overflow_q;

    // The head entry stays on the bus until it is acknowledged and popped.
    assign memReq       = ~empty;
    assign memAddress   = entries_q[head_q].addr;
    assign memWriteData = entries_q[head_q].data;

`ifdef STORE_BUFFER_FORWARD_EN

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Youngest-match forwarding: walk the valid entries from oldest to
    // youngest so a later match overrides an earlier one. Only registered
    // entries take part, so a store enqueuing this cycle is not seen.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int age = 0; age < DEPTH; age++) begin
            if ((CNT_W'(age) < count_q) &&
                (entries_q[head_q + PTR_W'(age)].addr == lookupAddress)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries_q[head_q + PTR_W'(age)].data;
            end
        end
    end

    assign lookupHit  = fwd_hit;
    assign lookupData = fwd_data;

`else

    // Forwarding disabled: the lookup port is inert and the address is only
    // folded into a dangling reduction so it is visibly consumed.
    logic unused_lookup_address;
    assign unused_lookup_address = ^lookupAddress;

    assign lookupHit  = 1'b0;
    assign lookupData = '0;

`endif

endmodule
